// File: rtl/display_pkg.sv
// Shared constants and types for the display scan controller.
// Contents: blank segment pattern, anode-off mask helper, scan FSM states.
package display_pkg;

  // All segments and the DP dark (pins are active-low).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // All-anodes-off mask for a display of 'digits' positions (up to 8).
  function automatic logic [7:0] an_off(input int unsigned digits);
    logic [8:0] mask;
    mask = (9'd1 << digits) - 9'd1;
    return mask[7:0];
  endfunction

endpackage

// File: rtl/scan_timebase.sv
// Slot timebase: prescaler counts cycles within a digit slot, idx selects the
// digit. Ports:
//   clk, rst        clock, synchronous active-high reset
//   idx             current digit index (0..DIGITS-1)
//   in_blank        prescaler is inside the anti-ghost blank window
//   show_start      last blank cycle of the slot (next cycle is SHOW)
//   slot_end        last cycle of the slot (prescaler wraps next)
//   frame_boundary  last cycle of the frame (idx wraps DIGITS-1 -> 0 next)
module scan_timebase
#(
  parameter  int unsigned DIGITS       = 4,
  parameter  int unsigned REFRESH_DIV  = 50000,
  parameter  int unsigned BLANK_CYCLES = 16,
  localparam int unsigned IW           = $clog2(DIGITS)
)
(
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx,
  output logic          in_blank,
  output logic          show_start,
  output logic          slot_end,
  output logic          frame_boundary
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] prescaler;

  assign slot_end       = (prescaler == PW'(REFRESH_DIV - 1));
  assign show_start     = (prescaler == PW'(BLANK_CYCLES - 1));
  assign in_blank       = (prescaler < PW'(BLANK_CYCLES));
  assign frame_boundary = slot_end && (idx == IW'(DIGITS - 1));

  // Prescaler and digit index advance together at the slot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (slot_end) begin
      prescaler <= '0;
      idx       <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// a shared external hex decoder. Ports:
//   clk, rst     clock, synchronous active-high reset
//   load         one-cycle strobe capturing value_in/dp_in
//   value_in     hex value, nibble i -> digit i (digit 0 rightmost)
//   dp_in        decimal point request per digit (1 = lit)
//   lz_en        leading-zero suppression enable
//   nibble_out   nibble for the shared decoder (combinational)
//   seg_in       decoder result, active-low, bit 7 = DP (decoder drives 1)
//   seg_out      registered segment pins, active-low
//   an_out       registered anode enables, active-low one-hot
//   load_ack     one-cycle pulse when a captured value becomes displayed
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [3:0]            nibble_out,
  input  logic [7:0]            seg_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  load_ack
);

  localparam int unsigned        IW     = $clog2(DIGITS);
  localparam int unsigned        VW     = 4 * DIGITS;
  localparam logic [DIGITS-1:0]  AN_OFF = DIGITS'(an_off(DIGITS));

  logic [IW-1:0]     idx;
  logic              in_blank;
  logic              show_start;
  logic              slot_end;
  logic              frame_boundary;

  logic [VW-1:0]     disp_val;
  logic [DIGITS-1:0] disp_dp;
  logic [VW-1:0]     pend_val;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_valid;

  logic              dp_cur;
  logic              suppress;
  logic              all_zero;

  scan_state_e       state;

  scan_timebase #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timebase (
    .clk            (clk),
    .rst            (rst),
    .idx            (idx),
    .in_blank       (in_blank),
    .show_start     (show_start),
    .slot_end       (slot_end),
    .frame_boundary (frame_boundary)
  );

  // Select the current digit's nibble/DP; all_zero accumulates from the MSB
  // down so a digit is a leading zero when it and every higher nibble are 0.
  always_comb begin
    nibble_out = 4'h0;
    dp_cur     = 1'b0;
    suppress   = 1'b0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (disp_val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nibble_out = disp_val[4*i +: 4];
        dp_cur     = disp_dp[i];
        suppress   = lz_en && all_zero && (i != 0);
      end
    end
  end

  // Scan FSM: state tracks the phase of the current prescaler value, outputs
  // are registered from it, giving one cycle of latency to the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BLANK;
      an_out  <= AN_OFF;
      seg_out <= SEG_BLANK;
    end else begin
      case (state)
        BLANK: begin
          an_out  <= AN_OFF;
          seg_out <= SEG_BLANK;
          if (show_start) state <= SHOW;
        end
        SHOW: begin
          an_out <= AN_OFF & ~(DIGITS'(1) << idx);
          // Suppressed digits keep their anode low but light nothing, DP included.
          if (suppress) seg_out <= SEG_BLANK;
          else          seg_out <= {~dp_cur & seg_in[7], seg_in[6:0]};
          if (slot_end) state <= BLANK;
        end
        default: begin
          state   <= BLANK;
          an_out  <= AN_OFF;
          seg_out <= SEG_BLANK;
        end
      endcase
    end
  end

  // State and prescaler window must agree; a mismatch means the FSM desynced.
  always_ff @(posedge clk) begin
    if (!rst) assert ((state == BLANK) == in_blank);
  end

  // Tear-free update: display only changes at the frame boundary. A load on
  // the boundary itself bypasses the pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (frame_boundary) begin
        if (load) begin
          disp_val   <= value_in;
          disp_dp    <= dp_in;
          pend_valid <= 1'b0;
          load_ack   <= 1'b1;
        end else if (pend_valid) begin
          disp_val   <= pend_val;
          disp_dp    <= pend_dp;
          pend_valid <= 1'b0;
          load_ack   <= 1'b1;
        end
      end else if (load) begin
        pend_val   <= value_in;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2). cyc counts clock edges since reset release; stimulus pushes
// expected pin values keyed by cyc and expected ack cycles, a monitor pops
// and compares them at each falling edge.
module tb_display_scan_ctrl;

  localparam int unsigned DIGITS = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [3:0]  nibble_out;
  logic [7:0]  seg_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        load_ack;

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [7:0] seg;
    logic [3:0] nib;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   cyc;
  int   checks;
  int   failures;
  exp_t e;

  display_scan_ctrl #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .nibble_out (nibble_out),
    .seg_in     (seg_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .load_ack   (load_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural decoder: active-low gfedcba, DP bit driven high.
  function automatic logic [7:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  always_comb seg_in = hex7(nibble_out);

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_val(input string name, input int n, input logic [7:0] act,
                           input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%02h required=%02h", name, n, act, req);
    end
  endtask

  // Monitor: compare pins at the cycles the scoreboard names, and pair every
  // load_ack pulse with an expected ack cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].n <= cyc) begin
      e = exp_q.pop_front();
      if (e.n < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_check cyc=%0d required_cyc=%0d", cyc, e.n);
      end else begin
        check_val("an_out", cyc, {4'h0, an_out}, {4'h0, e.an});
        check_val("seg_out", cyc, seg_out, e.seg);
        check_val("nibble_out", cyc, {4'h0, nibble_out}, {4'h0, e.nib});
      end
    end
    if (load_ack === 1'b1) begin
      checks++;
      if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack cyc=%0d rst=%0b", cyc, rst);
      end else if (ack_q[0] != cyc) begin
        failures++;
        $display("FAIL ack_cycle got=%0d required=%0d", cyc, ack_q[0]);
        void'(ack_q.pop_front());
      end else begin
        void'(ack_q.pop_front());
      end
    end
  end

  task automatic expect_at(input int n, input logic [3:0] an, input logic [7:0] seg,
                           input logic [3:0] nib);
    exp_q.push_back('{n, an, seg, nib});
  endtask

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout cyc=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] d);
    wait_until(n);
    load     = 1'b1;
    value_in = v;
    dp_in    = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Observation at cyc n shows the state of cycle n-1: slot s of frame f is
  // SHOW-checked at n = 32f + 8s + 5, and acks appear at n = 32f.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value_in = 16'h0000;
    dp_in    = 4'h0;
    lz_en    = 1'b0;

    // Reset values, then first SHOW of digit 0 at cycle 3.
    expect_at(0,  4'hF, 8'hFF, 4'h0);
    expect_at(1,  4'hF, 8'hFF, 4'h0);
    expect_at(2,  4'hF, 8'hFF, 4'h0);
    expect_at(3,  4'hE, 8'hC0, 4'h0);
    expect_at(5,  4'hE, 8'hC0, 4'h0);
    expect_at(13, 4'hD, 8'hC0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Mid-frame load: frame 0 unchanged, frame 1 shows 12A4 with DP on digit 1.
    wait_until(10);
    expect_at(21, 4'hB, 8'hC0, 4'h0);
    expect_at(29, 4'h7, 8'hC0, 4'h0);
    expect_at(32, 4'h7, 8'hC0, 4'h4);
    expect_at(33, 4'hF, 8'hFF, 4'h4);
    expect_at(37, 4'hE, 8'h99, 4'h4);
    expect_at(45, 4'hD, 8'h08, 4'hA);
    expect_at(53, 4'hB, 8'hA4, 4'h2);
    expect_at(61, 4'h7, 8'hF9, 4'h1);
    ack_q.push_back(32);
    do_load(10, 16'h12A4, 4'b0010);

    // Two loads in frame 2: only the latest reaches frame 3, one ack.
    wait_until(66);
    expect_at(77,  4'hD, 8'h08, 4'hA);
    expect_at(96,  4'h7, 8'hF9, 4'h2);
    expect_at(101, 4'hE, 8'hA4, 4'h2);
    expect_at(125, 4'h7, 8'hA4, 4'h2);
    ack_q.push_back(96);
    do_load(66, 16'h1111, 4'b0000);
    do_load(80, 16'h2222, 4'b0000);

    // Pending 3333 overtaken by a load on the boundary cycle (bypass).
    wait_until(110);
    expect_at(128, 4'h7, 8'hA4, 4'h0);
    expect_at(133, 4'hE, 8'hC0, 4'h0);
    expect_at(141, 4'hD, 8'h8E, 4'hF);
    expect_at(149, 4'hB, 8'hC0, 4'h0);
    expect_at(157, 4'h7, 8'hC0, 4'h0);
    ack_q.push_back(128);
    do_load(110, 16'h3333, 4'b0000);
    do_load(127, 16'h00F0, 4'b0000);

    // Leading-zero suppression: 0050 has nibbles 3 and 2 both leading zeros,
    // so both go dark; DP request on suppressed digit 3 stays off.
    wait_until(130);
    expect_at(165, 4'hE, 8'h40, 4'h0);
    expect_at(173, 4'hD, 8'h92, 4'h5);
    expect_at(181, 4'hB, 8'hFF, 4'h0);
    expect_at(189, 4'h7, 8'hFF, 4'h0);
    ack_q.push_back(160);
    do_load(130, 16'h0050, 4'b1001);
    wait_until(159);
    lz_en = 1'b1;
    expect_at(197, 4'hE, 8'hC0, 4'h0);
    expect_at(205, 4'hD, 8'hFF, 4'h0);
    expect_at(213, 4'hB, 8'hFF, 4'h0);
    expect_at(221, 4'h7, 8'hFF, 4'h0);
    ack_q.push_back(192);
    do_load(170, 16'h0000, 4'b0000);

    // Reset during SHOW of digit 2 with 9876 pending: discarded, no ack.
    wait_until(222);
    lz_en = 1'b0;
    expect_at(245, 4'hB, 8'hC0, 4'h0);
    do_load(226, 16'h9876, 4'b1111);
    wait_until(245);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_at(0, 4'hF, 8'hFF, 4'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_at(3,  4'hE, 8'hC0, 4'h0);
    expect_at(21, 4'hB, 8'hC0, 4'h0);
    expect_at(32, 4'h7, 8'hC0, 4'h0);
    expect_at(45, 4'hD, 8'hC0, 4'h0);
    expect_at(53, 4'hB, 8'hC0, 4'h0);
    wait_until(70);

    checks++;
    if (ack_q.size() != 0) begin
      failures++;
      $display("FAIL acks_outstanding got=%0d required=0", ack_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL checks_outstanding got=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
